// File: rtl/thruster_pkg.sv
// Shared types and defaults for the thruster command path (burn sequencer and velocity accumulator).
`default_nettype none

package thruster_pkg;

  localparam int THR_N  = 4;
  localparam int THR_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURN  = 2'd1,
    ST_COAST = 2'd2
  } burn_state_e;

  typedef struct packed {
    logic              dir;
    logic [THR_N-1:0]  mag;
    logic [THR_DW-1:0] dur;
  } burn_cmd_t;

  localparam int BURN_CMD_W = $bits(burn_cmd_t);

endpackage

`default_nettype wire

// File: rtl/burn_cmd_fifo.sv
// Burn command FIFO: power-of-two depth, synchronous flush, registered occupancy count.
`default_nettype none

module burn_cmd_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [LW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == LW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_q];
  assign level   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/burn_sequencer.sv
// Burn sequencer: queues burn commands and replays each as a timed up/down/thrust pulse train.
`default_nettype none

module burn_sequencer
  import thruster_pkg::*;
#(
  parameter int N     = THR_N,
  parameter int DW    = THR_DW,
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_dir,
  input  logic [N-1:0]             cmd_mag,
  input  logic [DW-1:0]            cmd_dur,
  input  logic                     abort,
  output logic                     up,
  output logic                     down,
  output logic [N-1:0]             thrust,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(GAP + 2);
  localparam int CW = (DW > GW) ? DW : GW;

  typedef struct packed {
    logic          dir;
    logic [N-1:0]  mag;
    logic [DW-1:0] dur;
  } cmd_t;

  cmd_t          wr_cmd;
  cmd_t          head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          take;
  logic          last;
  logic [LW-1:0] fifo_level;
  logic [LW-1:0] level_next;

  burn_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          up_q, up_d;
  logic          down_q, down_d;
  logic [N-1:0]  thrust_q, thrust_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  assign cmd_ready = !full && !abort;
  assign push      = cmd_valid && cmd_ready;
  assign wr_cmd    = {cmd_dir, cmd_mag, cmd_dur};

  burn_cmd_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .wdata (wr_cmd),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    up_d     = 1'b0;
    down_d   = 1'b0;
    thrust_d = '0;
    done_d   = 1'b0;
    take     = 1'b0;
    pop      = 1'b0;
    last     = (cnt_q == CW'(1));

    case (state_q)
      ST_IDLE: take = !empty;
      ST_BURN: begin
        up_d     = up_q;
        down_d   = down_q;
        thrust_d = thrust_q;
        cnt_d    = cnt_q - CW'(1);
        if (last) begin
          up_d     = 1'b0;
          down_d   = 1'b0;
          thrust_d = '0;
          done_d   = 1'b1;
          if (GAP > 0) begin
            state_d = ST_COAST;
            cnt_d   = CW'(GAP);
          end else begin
            state_d = ST_IDLE;
            // A zero-length head waits one cycle so its done pulse stays distinct.
            take    = !empty && (head.dur != '0);
          end
        end
      end
      ST_COAST: begin
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          state_d = ST_IDLE;
          take    = !empty;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      pop = 1'b1;
      if (head.dur != '0) begin
        state_d  = ST_BURN;
        cnt_d    = CW'(head.dur);
        up_d     = head.dir;
        down_d   = !head.dir;
        thrust_d = head.mag;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end

    if (abort) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      pop      = 1'b0;
      up_d     = 1'b0;
      down_d   = 1'b0;
      thrust_d = '0;
      done_d   = 1'b0;
    end
  end

  assign level_next = abort ? '0 : (fifo_level + LW'(push) - LW'(pop));
  assign busy_d     = (state_d != ST_IDLE) || (level_next != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      thrust_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      up_q     <= up_d;
      down_q   <= down_d;
      thrust_q <= thrust_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign up     = up_q;
  assign down   = down_q;
  assign thrust = thrust_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign level  = fifo_level;

endmodule

`default_nettype wire

// File: tb/tb_burn_sequencer.sv
// Randomized bench for burn_sequencer against a schedule-level reference model.
`default_nettype none

module tb_burn_sequencer;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int GAP   = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dir = 1'b0;
  logic [N-1:0]  cmd_mag = '0;
  logic [DW-1:0] cmd_dur = '0;
  logic          abort = 1'b0;
  logic          up, down, busy, done;
  logic [N-1:0]  thrust;
  logic [$clog2(DEPTH):0] level;

  burn_sequencer #(.N(N), .DW(DW), .DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_mag(cmd_mag), .cmd_dur(cmd_dur), .abort(abort),
    .up(up), .down(down), .thrust(thrust), .busy(busy), .done(done), .level(level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each popped command occupies a window of edges; the next pop is
  // allowed dur+GAP edges later (one edge later for a zero-length command).
  typedef struct {bit dir; int mag; int dur;} mcmd_t;
  mcmd_t q[$];
  mcmd_t cur;
  int    cyc, burn_start, burn_end, done_edge, next_pop;
  bit    last_burn;
  int    dut_vel;

  task automatic model_reset();
    q.delete();
    cur = '{0, 0, 0};
    burn_start = 0; burn_end = 0; done_edge = -1; next_pop = 0; last_burn = 0;
  endtask

  task automatic model_edge(input int e, input bit push_ok, input bit ab, input mcmd_t nc);
    if (ab) begin
      q.delete();
      burn_end = e; done_edge = -1; next_pop = e + 1; last_burn = 0;
    end else begin
      if (q.size() > 0 && e >= next_pop) begin
        cur        = q.pop_front();
        burn_start = e;
        burn_end   = e + cur.dur;
        done_edge  = e + cur.dur;
        next_pop   = (cur.dur > 0) ? e + cur.dur + GAP : e + 1;
        last_burn  = (cur.dur > 0);
      end
      if (push_ok) q.push_back(nc);
    end
  endtask

  task automatic check_outputs(input int k);
    bit act;
    act = (k >= burn_start) && (k < burn_end);
    chk_eq("up",     up,     act && cur.dir);
    chk_eq("down",   down,   act && !cur.dir);
    chk_eq("thrust", thrust, act ? cur.mag : 0);
    chk_eq("done",   done,   k == done_edge);
    chk_eq("busy",   busy,   (q.size() > 0) || (last_burn && k < next_pop));
    chk_eq("level",  level,  q.size());
    if (up)        dut_vel += int'(thrust);
    else if (down) dut_vel -= int'(thrust);
  endtask

  // Called at a falling edge: drive inputs, check ready, advance model and DUT one edge.
  task automatic cycle(input bit v, input bit d, input int m, input int du, input bit ab);
    bit    exp_ready;
    mcmd_t nc;
    cmd_valid = v; cmd_dir = d; cmd_mag = N'(m); cmd_dur = DW'(du); abort = ab;
    #1;
    exp_ready = (q.size() < DEPTH) && !ab;
    chk_eq("cmd_ready", cmd_ready, exp_ready);
    nc = '{d, m, du};
    model_edge(cyc + 1, v && exp_ready, ab, nc);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc = 0;
    dut_vel = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_eq("rst_ready", cmd_ready, 1);
    check_outputs(cyc);

    // Single CW burn mag=3 dur=5: velocity 0 -> 15.
    dut_vel = 0;
    cycle(1, 1, 3, 5, 0);
    idle(9);
    chk_eq("vel_single", dut_vel & 15, 15);

    // CW 2x3 then CCW 1x4: net velocity 2.
    dut_vel = 0;
    cycle(1, 1, 2, 3, 0);
    cycle(1, 0, 1, 4, 0);
    idle(12);
    chk_eq("vel_pair", dut_vel & 15, 2);

    // dur=0 between two dur=2 burns.
    cycle(1, 1, 5, 2, 0);
    cycle(1, 0, 7, 0, 0);
    cycle(1, 0, 4, 2, 0);
    idle(10);

    // Fill the FIFO behind a long burn.
    cycle(1, 1, 1, 20, 0);
    for (int i = 0; i < 5; i++) cycle(1, i[0], i + 1, i + 1, 0);
    idle(50);

    // Abort on the 3rd cycle of a dur=10 burn with 2 queued.
    cycle(1, 1, 6, 10, 0);
    cycle(1, 0, 2, 3, 0);
    cycle(1, 1, 3, 4, 0);
    cycle(0, 0, 0, 0, 1);
    chk_eq("abort_level", level, 0);
    chk_eq("abort_busy", busy, 0);
    idle(2);
    cycle(1, 0, 9, 3, 0);
    idle(6);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      int du;
      du = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15), du,
            $urandom_range(0, 59) == 0);
    end
    idle(80);

    // Asynchronous reset in the middle of a burn.
    cycle(1, 1, 7, 8, 0);
    cycle(1, 0, 3, 2, 0);
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_up", up, 0);
    chk_eq("arst_thrust", thrust, 0);
    chk_eq("arst_level", level, 0);
    chk_eq("arst_ready", cmd_ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs(cyc);
    cycle(1, 0, 5, 3, 0);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
